// File: rtl/snitch_icache_perf_cnt.sv
// snitch_icache_perf_cnt: per-event performance counters fed by the icache L0/L1 event vectors.
// Ports: clk_i/rst_ni clock and async active-low reset; l0_events_i five event bits per fetch port;
// l1_events_i four L1 event bits; req_i/we_i/addr_i/wdata_i register request; gnt_o grant;
// rvalid_o/rdata_o/err_o registered response one cycle after each request.
module snitch_icache_perf_cnt #(
  parameter int NR_FETCH_PORTS = 4,
  parameter int CNT_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [5*NR_FETCH_PORTS-1:0] l0_events_i,
  input  logic [3:0]                  l1_events_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [3:0]                  addr_i,
  input  logic [31:0]                 wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o
);
  localparam int PW = $clog2(NR_FETCH_PORTS + 1);
  logic [8:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0][PW-1:0] inc;
  logic [8:0][CNT_W:0] sum;
  logic [8:0] ovf_q, ovf_d, ovf_new;
  logic en_q, en_d, sat_q, sat_d, rvalid_q, err_q;
  logic [31:0] rdata_q, rd_val;
  logic wr, wr_cnt, wr_ctrl, wr_ovf;
  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign wr      = req_i & we_i;
  assign wr_cnt  = wr & (addr_i < 4'd9);
  assign wr_ctrl = wr & (addr_i == 4'd9);
  assign wr_ovf  = wr & (addr_i == 4'd10);
  // Counter k (0..4) takes L0 event bit 4-k summed over ports; counter 5+k takes L1 bit 3-k.
  always_comb begin
    inc = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++)
      for (int e = 0; e < 5; e++)
        inc[e] = inc[e] + PW'(l0_events_i[5*p+4-e]);
    for (int e = 0; e < 4; e++)
      inc[5+e] = PW'(l1_events_i[3-e]);
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++)
      sum[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc[i]);
  end
  // Priority, lowest to highest: increment, register write, clear.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_new = '0;
    for (int i = 0; i < 9; i++) begin
      ovf_new[i] = en_q & sum[i][CNT_W];
      if (en_q) cnt_d[i] = (sat_q & sum[i][CNT_W]) ? {CNT_W{1'b1}} : sum[i][CNT_W-1:0];
    end
    if (wr_cnt) begin
      cnt_d[addr_i]   = wdata_i[CNT_W-1:0];
      ovf_new[addr_i] = 1'b0;
    end
    ovf_d = (ovf_q & ~(wr_ovf ? wdata_i[8:0] : 9'd0)) | ovf_new;
    en_d  = wr_ctrl ? wdata_i[0] : en_q;
    sat_d = wr_ctrl ? wdata_i[1] : sat_q;
    if (wr_ctrl & wdata_i[2]) begin
      cnt_d = '0;
      ovf_d = '0;
    end
  end
  // Reads return pre-update state; writes and unmapped indices respond with zero.
  assign rd_val = we_i             ? 32'd0 :
                  (addr_i < 4'd9)  ? 32'(cnt_q[addr_i]) :
                  (addr_i == 4'd9) ? {30'd0, sat_q, en_q} :
                  (addr_i == 4'd10) ? {23'd0, ovf_q} : 32'd0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      ovf_q    <= '0;
      en_q     <= 1'b1;
      sat_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      sat_q    <= sat_d;
      rvalid_q <= req_i;
      if (req_i) begin
        rdata_q <= rd_val;
        err_q   <= addr_i > 4'd10;
      end
    end
  end
endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// tb_snitch_icache_perf_cnt: directed bench for the icache performance counters (4 ports, 8-bit counters).
module tb_snitch_icache_perf_cnt;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [19:0] l0_events_i = '0;
  logic [3:0] l1_events_i = '0;
  logic req_i = 1'b0, we_i = 1'b0;
  logic [3:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  int total = 0, passed = 0;
  logic [31:0] r;
  logic e;
  snitch_icache_perf_cnt #(.NR_FETCH_PORTS(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .l0_events_i(l0_events_i), .l1_events_i(l1_events_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    #1 chk("gnt", {31'd0, gnt_o}, 32'd1);
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0;
    chk("rvalid", {31'd0, rvalid_o}, 32'd1);
    rd = rdata_o; er = err_o;
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    logic x;
    acc(1'b0, a, 32'd0, v, x);
    chk(tag, v, exp);
    chk({tag, "_err"}, {31'd0, x}, 32'd0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic x;
    acc(1'b1, a, d, v, x);
    chk("wr_rdata", v, 32'd0);
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  initial begin
    #2;
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    #13 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // 1: reset values of every mapped register, back-to-back reads
    for (int i = 0; i < 9; i++) rd_chk("rst_cnt", 4'(i), 32'd0);
    rd_chk("rst_ctrl", 4'd9, 32'h1);
    rd_chk("rst_ovf", 4'd10, 32'h0);
    cyc(1);
    chk("rvalid_idle", {31'd0, rvalid_o}, 32'd0);
    // 2: l0_hit on all four ports for 10 cycles, l1_miss for the first 3
    l0_events_i = {4{5'h08}};
    l1_events_i = 4'h8;
    cyc(3);
    l1_events_i = 4'h0;
    cyc(7);
    l0_events_i = '0;
    cyc(1);
    rd_chk("l0_hit40", 4'd1, 32'd40);
    rd_chk("l1_miss3", 4'd5, 32'd3);
    rd_chk("l0_miss0", 4'd0, 32'd0);
    rd_chk("l1_hit0", 4'd6, 32'd0);
    // 3: wrap with SAT=0, then saturate with SAT=1
    wr(4'd0, 32'hFE);
    l0_events_i = {5'h00, {3{5'h10}}};
    cyc(1);
    l0_events_i = '0;
    rd_chk("wrap", 4'd0, 32'h01);
    rd_chk("ovf_wrap", 4'd10, 32'h001);
    wr(4'd10, 32'h1);
    rd_chk("ovf_w1c", 4'd10, 32'h0);
    wr(4'd9, 32'h3);
    rd_chk("ctrl_sat", 4'd9, 32'h3);
    wr(4'd0, 32'hFE);
    l0_events_i = {5'h00, {3{5'h10}}};
    cyc(1);
    rd_chk("sat_ff", 4'd0, 32'hFF);
    cyc(2);
    l0_events_i = '0;
    rd_chk("sat_hold", 4'd0, 32'hFF);
    rd_chk("ovf_sat", 4'd10, 32'h001);
    // 4: write beats same-cycle increment; reads see pre-update value
    l1_events_i = 4'h4;
    wr(4'd6, 32'h155);
    l1_events_i = 4'h0;
    rd_chk("wr_wins", 4'd6, 32'h55);
    l1_events_i = 4'h4;
    rd_chk("rd_pre", 4'd6, 32'h55);
    l1_events_i = 4'h0;
    rd_chk("rd_post", 4'd6, 32'h56);
    l0_events_i = '1;
    l1_events_i = 4'hF;
    wr(4'd9, 32'h5);
    l0_events_i = '0;
    l1_events_i = 4'h0;
    for (int i = 0; i < 9; i++) rd_chk("clr_cnt", 4'(i), 32'd0);
    rd_chk("clr_ctrl", 4'd9, 32'h1);
    rd_chk("clr_ovf", 4'd10, 32'h0);
    // 5: EN=0 freezes counters; OVF write-1-to-clear
    wr(4'd1, 32'h22);
    wr(4'd5, 32'hFF);
    wr(4'd7, 32'hFF);
    l1_events_i = 4'hA;
    cyc(1);
    l1_events_i = 4'h0;
    rd_chk("ovf57", 4'd10, 32'h0A0);
    wr(4'd9, 32'h0);
    for (int i = 0; i < 20; i++) begin
      l0_events_i = (i % 2 == 0) ? 20'hFFFFF : 20'h5A5A5;
      l1_events_i = 4'(i);
      cyc(1);
    end
    l0_events_i = '0;
    l1_events_i = 4'h0;
    rd_chk("en0_l0hit", 4'd1, 32'h22);
    rd_chk("en0_l1miss", 4'd5, 32'h0);
    rd_chk("en0_l0miss", 4'd0, 32'h0);
    rd_chk("en0_ovf", 4'd10, 32'h0A0);
    wr(4'd10, 32'h1FF);
    rd_chk("ovf_clr", 4'd10, 32'h0);
    // 6: unmapped access, then async reset with a response pending
    acc(1'b0, 4'd13, 32'd0, r, e);
    chk("unmap_rd", r, 32'd0);
    chk("unmap_rd_err", {31'd0, e}, 32'd1);
    acc(1'b1, 4'd14, 32'hFFFF_FFFF, r, e);
    chk("unmap_wr", r, 32'd0);
    chk("unmap_wr_err", {31'd0, e}, 32'd1);
    rd_chk("unmap_nofx", 4'd1, 32'h22);
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'd1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_mid_rdata", rdata_o, 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rd_chk("rst_mid_cnt", 4'd1, 32'd0);
    rd_chk("rst_mid_ctrl", 4'd9, 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
